// File: rtl/lcd_queue_feeder.sv
// ---------------------------------------------------------------------------
// lcd_queue_feeder
//
// Purpose:
//   Converts a tagged pixel stream from the frame-buffer reader into the
//   17-bit token stream consumed by the LCD controller through the display
//   FIFO. Every frame is normalised to exactly
//   LCD_SCREEN_WIDTH x LCD_SCREEN_HEIGHT pixels:
//     - long rows and surplus rows are cropped;
//     - short rows and missing rows are padded with PAD_COLOR.
//   Token encoding:
//     17'h10000 frame start, 17'h10001 row start, 17'h1FFFF frame end,
//     {1'b0, RGB565} pixel.
//
// Ports:
//   clk            in   1   single clock, shared with the FIFO write side
//   reset          in   1   synchronous, active-high reset
//   in_valid       in   1   input beat valid
//   in_ready       out  1   beat accepted when in_valid & in_ready
//   in_data        in  16   RGB565 pixel (ignored for marker beats)
//   in_tag         in   2   00 pixel, 01 SOF, 10 SOL, 11 EOF
//   queue_data_out out 17   token to FIFO
//   queue_wr_en    out  1   FIFO write strobe
//   queue_full     in   1   FIFO full flag
//   frame_count    out 16   completed frames (statistics build only)
//   drop_count     out 16   discarded pixel beats (statistics build only)
//
// Build option:
//   LCD_QUEUE_FEEDER_STATS_EN - when defined, frame_count / drop_count are
//   live saturating counters; when undefined both ports are tied to zero.
//   Token behaviour is identical in both builds.
// ---------------------------------------------------------------------------
module lcd_queue_feeder #(
  parameter int          LCD_SCREEN_WIDTH  = 480,
  parameter int          LCD_SCREEN_HEIGHT = 272,
  parameter logic [15:0] PAD_COLOR         = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_tag,
  output logic [16:0] queue_data_out,
  output logic        queue_wr_en,
  input  logic        queue_full,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  localparam logic [10:0] WIDTH    = 11'(LCD_SCREEN_WIDTH);
  localparam logic [10:0] HEIGHT   = 11'(LCD_SCREEN_HEIGHT);
  localparam logic [10:0] WIDTH_M1 = WIDTH - 11'd1;

  localparam logic [1:0] TAG_PIX = 2'b00;
  localparam logic [1:0] TAG_SOF = 2'b01;
  localparam logic [1:0] TAG_SOL = 2'b10;
  localparam logic [1:0] TAG_EOF = 2'b11;

  localparam logic [16:0] TOK_SOF = 17'h10000;
  localparam logic [16:0] TOK_SOL = 17'h10001;
  localparam logic [16:0] TOK_EOF = 17'h1FFFF;
  localparam logic [16:0] TOK_PAD = {1'b0, PAD_COLOR};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FRAME     = 3'd1,
    S_LINE      = 3'd2,
    S_PAD_PIX   = 3'd3,
    S_SKIP_LINE = 3'd4,
    S_PAD_ROWS  = 3'd5,
    S_END       = 3'd6
  } state_e;

  state_e      state_q, state_d;

  // one-entry output token slot
  logic [16:0] tok_q;
  logic        tok_vld_q;

  // col: pixels emitted in current row; row: rows started in current frame
  logic [10:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  // set while PAD_ROWS is emitting the pad pixels of a synthesised row
  logic        row_open_q, row_open_d;

  logic        slot_free;
  logic        load;
  logic [16:0] load_tok;
  logic        in_ready_c;
  logic        fire;
  logic        is_pix, is_sol, is_eof, is_sof;
  logic        col_lt_w, row_lt_h, col_last;

  assign is_pix   = (in_tag == TAG_PIX);
  assign is_sol   = (in_tag == TAG_SOL);
  assign is_eof   = (in_tag == TAG_EOF);
  assign is_sof   = (in_tag == TAG_SOF);
  assign col_lt_w = (col_q < WIDTH);
  assign row_lt_h = (row_q < HEIGHT);
  assign col_last = (col_q == WIDTH_M1);

  // The slot can take a new token when empty or when it drains this cycle.
  assign slot_free = ~tok_vld_q | ~queue_full;

  assign queue_wr_en    = tok_vld_q & ~queue_full & ~reset;
  assign queue_data_out = tok_q;
  assign in_ready       = in_ready_c & ~reset;
  assign fire           = in_valid & in_ready_c;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fire && is_sof) state_d = S_FRAME;
      end
      S_FRAME: begin
        if (in_valid) begin
          if (is_sol && fire) begin
            state_d = row_lt_h ? S_LINE : S_SKIP_LINE;
          end else if (is_eof || is_sof) begin
            state_d = S_PAD_ROWS;
          end
        end
      end
      S_LINE: begin
        // A marker ends the row. A short row emits its first pad right
        // here, so the pad sequence starts without a dead cycle.
        if (in_valid && !is_pix) begin
          if (!col_lt_w) begin
            state_d = S_FRAME;
          end else if (slot_free) begin
            state_d = col_last ? S_FRAME : S_PAD_PIX;
          end
        end
      end
      S_PAD_PIX: begin
        if (slot_free && col_last) state_d = S_FRAME;
      end
      S_SKIP_LINE: begin
        if (in_valid && (is_eof || is_sof)) state_d = S_PAD_ROWS;
      end
      S_PAD_ROWS: begin
        if (!row_open_q && !row_lt_h) state_d = S_END;
      end
      S_END: begin
        // Pending EOF is consumed here; a pending SOF is left for IDLE.
        if (slot_free) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath decode
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready_c = 1'b0;
    load       = 1'b0;
    load_tok   = '0;
    col_d      = col_q;
    row_d      = row_q;
    row_open_d = row_open_q;
    unique case (state_q)
      S_IDLE: begin
        // Everything but SOF is thrown away without touching the slot.
        in_ready_c = is_sof ? slot_free : 1'b1;
        if (fire && is_sof) begin
          load       = 1'b1;
          load_tok   = TOK_SOF;
          row_d      = '0;
          col_d      = '0;
          row_open_d = 1'b0;
        end
      end
      S_FRAME: begin
        if (is_sol) begin
          in_ready_c = row_lt_h ? slot_free : 1'b1;
          if (fire && row_lt_h) begin
            load     = 1'b1;
            load_tok = TOK_SOL;
            col_d    = '0;
            row_d    = row_q + 11'd1;
          end
        end else if (is_pix) begin
          in_ready_c = 1'b1;
        end
      end
      S_LINE: begin
        if (is_pix) begin
          in_ready_c = col_lt_w ? slot_free : 1'b1;
          if (fire && col_lt_w) begin
            load     = 1'b1;
            load_tok = {1'b0, in_data};
            col_d    = col_q + 11'd1;
          end
        end else if (in_valid && col_lt_w && slot_free) begin
          load     = 1'b1;
          load_tok = TOK_PAD;
          col_d    = col_q + 11'd1;
        end
      end
      S_PAD_PIX: begin
        if (slot_free) begin
          load     = 1'b1;
          load_tok = TOK_PAD;
          col_d    = col_q + 11'd1;
        end
      end
      S_SKIP_LINE: begin
        in_ready_c = is_pix | is_sol;
      end
      S_PAD_ROWS: begin
        if (slot_free) begin
          if (row_open_q) begin
            load     = 1'b1;
            load_tok = TOK_PAD;
            col_d    = col_q + 11'd1;
            if (col_last) row_open_d = 1'b0;
          end else if (row_lt_h) begin
            load       = 1'b1;
            load_tok   = TOK_SOL;
            row_d      = row_q + 11'd1;
            col_d      = '0;
            row_open_d = 1'b1;
          end
        end
      end
      S_END: begin
        in_ready_c = is_eof & slot_free;
        if (slot_free) begin
          load     = 1'b1;
          load_tok = TOK_EOF;
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Counters and token slot
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      row_open_q <= 1'b0;
      tok_q      <= '0;
      tok_vld_q  <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_open_q <= row_open_d;
      // A load while the old token drains refills the slot with no bubble.
      if (load) begin
        tok_q     <= load_tok;
        tok_vld_q <= 1'b1;
      end else if (queue_wr_en) begin
        tok_vld_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
`ifdef LCD_QUEUE_FEEDER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;
  logic        frame_inc;
  logic        drop_inc;

  // Every 1FFFF load completes a frame; an accepted pixel that does not
  // load a token was discarded.
  assign frame_inc = (state_q == S_END) & slot_free;
  assign drop_inc  = fire & is_pix & ~load;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (frame_inc && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop_inc && (drop_cnt_q != 16'hFFFF))   drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_lcd_queue_feeder.sv
// ---------------------------------------------------------------------------
// tb_lcd_queue_feeder
//
// Drives tagged beat streams into lcd_queue_feeder (4x3 screen, pad colour
// ABCD) and compares the written token stream and the statistics ports with
// a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_lcd_queue_feeder;

  localparam int          W   = 4;
  localparam int          H   = 3;
  localparam logic [15:0] PAD = 16'hABCD;
  localparam int          FRAME_TOKENS = 2 + H * (1 + W);

  localparam logic [1:0] T_PIX = 2'b00;
  localparam logic [1:0] T_SOF = 2'b01;
  localparam logic [1:0] T_SOL = 2'b10;
  localparam logic [1:0] T_EOF = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_tag = T_PIX;
  logic [16:0] queue_data_out;
  logic        queue_wr_en;
  logic        queue_full = 1'b0;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  lcd_queue_feeder #(
    .LCD_SCREEN_WIDTH (W),
    .LCD_SCREEN_HEIGHT(H),
    .PAD_COLOR        (PAD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_tag        (in_tag),
    .queue_data_out(queue_data_out),
    .queue_wr_en   (queue_wr_en),
    .queue_full    (queue_full),
    .frame_count   (frame_count),
    .drop_count    (drop_count)
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] data;
  } beat_t;

  beat_t       beats[$];
  logic [16:0] got[$];
  logic [16:0] exp_q[$];
  logic [16:0] ref_run[$];
  int          exp_frames, exp_drops;
  int          stalls[256];
  int          viol, first_fire, first_wr;
  int          n_chk = 0;
  int          n_pass = 0;

  // reference-model frame buffer
  logic [15:0] m_pix[H][W];
  int          m_lens[H];

  // ---------------- stimulus helpers ----------------
  task automatic add(input logic [1:0] tag, input logic [15:0] data);
    beat_t b;
    b.tag = tag;
    b.data = data;
    beats.push_back(b);
  endtask

  task automatic add_row(input int npix);
    add(T_SOL, 16'h0);
    for (int i = 0; i < npix; i++) add(T_PIX, 16'($urandom));
  endtask

  // ---------------- reference model ----------------
  task automatic emit_frame();
    exp_q.push_back(17'h10000);
    for (int r = 0; r < H; r++) begin
      exp_q.push_back(17'h10001);
      for (int c = 0; c < W; c++)
        exp_q.push_back((c < m_lens[r]) ? {1'b0, m_pix[r][c]} : {1'b0, PAD});
    end
    exp_q.push_back(17'h1FFFF);
    exp_frames++;
  endtask

  // A frame runs from SOF to the next EOF or SOF; rows are whatever the SOL
  // markers delimit. Pixels outside a frame, before the first SOL, past the
  // screen width or in rows past the screen height are dropped.
  task automatic ref_model();
    bit in_frame = 0;
    int nrows = 0;
    exp_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    foreach (beats[i]) begin
      case (beats[i].tag)
        T_SOF: begin
          if (in_frame) emit_frame();
          in_frame = 1;
          nrows = 0;
          for (int r = 0; r < H; r++) m_lens[r] = 0;
        end
        T_EOF: begin
          if (in_frame) emit_frame();
          in_frame = 0;
        end
        T_SOL: begin
          if (in_frame) nrows++;
        end
        default: begin
          if (!in_frame || nrows == 0 || nrows > H) exp_drops++;
          else if (m_lens[nrows-1] >= W) exp_drops++;
          else begin
            m_pix[nrows-1][m_lens[nrows-1]] = beats[i].data;
            m_lens[nrows-1]++;
          end
        end
      endcase
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int v);
    int lim;
    lim = v;
`ifndef LCD_QUEUE_FEEDER_STATS_EN
    lim = 0;
`endif
    return (lim > 65535) ? 16'hFFFF : 16'(lim);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) return i;
    if (got.size() != exp_q.size())
      return (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    return -1;
  endfunction

  // ---------------- driver / monitor ----------------
  task automatic present(input int idx, input int gap_pct);
    if (idx < beats.size()) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_tag   = beats[idx].tag;
      in_data  = beats[idx].data;
    end else begin
      in_valid = 1'b0;
      in_tag   = T_PIX;
      in_data  = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    queue_full = 1'b0;
    in_tag = T_PIX;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Sends all of beats[], holding each one until accepted, and collects
  // every token written. Ends once the DUT has been quiet long enough.
  task automatic run_stream(input int full_pct, input int gap_pct);
    int idx = 0;
    int cyc = 0;
    int quiet = 0;
    bit fire;
    got.delete();
    viol = 0;
    first_fire = -1;
    first_wr = -1;
    for (int i = 0; i < 256; i++) stalls[i] = 0;
    present(0, gap_pct);
    queue_full = ($urandom_range(0, 99) < full_pct);
    forever begin
      @(negedge clk);
      if (queue_wr_en) begin
        got.push_back(queue_data_out);
        if (first_wr < 0) first_wr = cyc;
      end
      if (queue_wr_en && queue_full) viol++;
      fire = in_valid && in_ready;
      if (in_valid && !in_ready && idx < 256) stalls[idx]++;
      if (fire && first_fire < 0) first_fire = cyc;
      if (queue_wr_en) quiet = 0;
      else if (idx >= beats.size() && !queue_full) quiet++;
      if (quiet >= 8) break;
      if (cyc >= 5000) begin
        n_chk++;
        $display("FAIL stream_timeout: stuck at beat %0d of %0d after %0d cycles, required completion",
                 idx, beats.size(), cyc);
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (fire || !in_valid) begin
        if (fire) idx++;
        present(idx, gap_pct);
      end
      queue_full = ($urandom_range(0, 99) < full_pct);
    end
    in_valid = 1'b0;
    queue_full = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_tag = T_SOF;
    queue_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (queue_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b required 0", queue_wr_en);
    else n_pass++;
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    in_tag = T_PIX;
    @(negedge clk);
    n_chk++;
    if (queue_data_out !== 17'h0) $display("FAIL reset_data: got %h required 00000", queue_data_out);
    else n_pass++;
    n_chk++;
    if (queue_wr_en !== 1'b0) $display("FAIL reset_wr_after: got %b required 0", queue_wr_en);
    else n_pass++;
    n_chk++;
    if (frame_count !== 16'h0 || drop_count !== 16'h0)
      $display("FAIL reset_counters: got frame=%h drop=%h required 0/0", frame_count, drop_count);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    int d;
    do_reset();
    beats.delete();
    add(T_SOF, 16'h0);
    for (int r = 0; r < H; r++) add_row(W);
    add(T_EOF, 16'h0);
    ref_model();
    run_stream(0, 0);
    d = first_diff();
    n_chk++;
    if (d >= 0) $display("FAIL full_frame_tokens: index %0d got %h required %h (%0d vs %0d tokens)",
                         d, (d < got.size()) ? got[d] : 17'h0, (d < exp_q.size()) ? exp_q[d] : 17'h0,
                         got.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (got.size() != FRAME_TOKENS) $display("FAIL full_frame_count: got %0d required %0d", got.size(), FRAME_TOKENS);
    else n_pass++;
    n_chk++;
    if (first_wr != first_fire + 1)
      $display("FAIL full_frame_latency: first write cycle %0d required %0d", first_wr, first_fire + 1);
    else n_pass++;
    n_chk++;
    if (frame_count !== exp_cnt(1)) $display("FAIL full_frame_fcnt: got %h required %h", frame_count, exp_cnt(1));
    else n_pass++;
  endtask

  task automatic test_short_row();
    int d;
    do_reset();
    beats.delete();
    add(T_SOF, 16'h0);
    add(T_SOL, 16'h0);
    add(T_PIX, 16'h1234);
    add(T_PIX, 16'h5678);
    add_row(W);
    add_row(W);
    add(T_EOF, 16'h0);
    ref_model();
    run_stream(0, 0);
    d = first_diff();
    n_chk++;
    if (d >= 0) $display("FAIL short_row_tokens: index %0d got %h required %h (%0d vs %0d tokens)",
                         d, (d < got.size()) ? got[d] : 17'h0, (d < exp_q.size()) ? exp_q[d] : 17'h0,
                         got.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (got.size() < 6 || got[4] !== {1'b0, PAD} || got[5] !== {1'b0, PAD})
      $display("FAIL short_row_pads: got %0d tokens, required pads %h at 4 and 5", got.size(), {1'b0, PAD});
    else n_pass++;
    n_chk++;
    if (stalls[4] != 2) $display("FAIL short_row_stall: in_ready low %0d cycles required 2", stalls[4]);
    else n_pass++;
  endtask

  task automatic test_missing_rows();
    int d;
    do_reset();
    beats.delete();
    add(T_SOF, 16'h0);
    add_row(W);
    add(T_EOF, 16'h0);
    ref_model();
    run_stream(0, 0);
    d = first_diff();
    n_chk++;
    if (d >= 0) $display("FAIL missing_rows_tokens: index %0d got %h required %h (%0d vs %0d tokens)",
                         d, (d < got.size()) ? got[d] : 17'h0, (d < exp_q.size()) ? exp_q[d] : 17'h0,
                         got.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (got.size() != FRAME_TOKENS) $display("FAIL missing_rows_count: got %0d required %0d", got.size(), FRAME_TOKENS);
    else n_pass++;
    n_chk++;
    if (frame_count !== exp_cnt(1)) $display("FAIL missing_rows_fcnt: got %h required %h", frame_count, exp_cnt(1));
    else n_pass++;
  endtask

  task automatic test_crop();
    int d;
    do_reset();
    beats.delete();
    add(T_SOF, 16'h0);
    add_row(W + 2);
    add_row(W);
    add_row(W);
    add_row(W);
    add(T_EOF, 16'h0);
    ref_model();
    run_stream(0, 0);
    d = first_diff();
    n_chk++;
    if (d >= 0) $display("FAIL crop_tokens: index %0d got %h required %h (%0d vs %0d tokens)",
                         d, (d < got.size()) ? got[d] : 17'h0, (d < exp_q.size()) ? exp_q[d] : 17'h0,
                         got.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (got.size() != FRAME_TOKENS) $display("FAIL crop_count: got %0d required %0d", got.size(), FRAME_TOKENS);
    else n_pass++;
    n_chk++;
    if (drop_count !== exp_cnt(6)) $display("FAIL crop_drops: got %h required %h", drop_count, exp_cnt(6));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int d;
    int nr;
    do_reset();
    beats.delete();
    add(T_PIX, 16'($urandom));
    add(T_SOL, 16'h0);
    add(T_EOF, 16'h0);
    for (int f = 0; f < 4; f++) begin
      add(T_SOF, 16'h0);
      if ($urandom_range(0, 3) == 0) add(T_PIX, 16'($urandom));
      nr = $urandom_range(0, H + 1);
      for (int r = 0; r < nr; r++) add_row($urandom_range(0, W + 2));
      if (f == 3 || $urandom_range(0, 2) != 0) add(T_EOF, 16'h0);
    end
    ref_model();
    run_stream(0, 0);
    ref_run = got;
    do_reset();
    run_stream(50, 25);
    d = first_diff();
    n_chk++;
    if (d >= 0) $display("FAIL bp_tokens: index %0d got %h required %h (%0d vs %0d tokens)",
                         d, (d < got.size()) ? got[d] : 17'h0, (d < exp_q.size()) ? exp_q[d] : 17'h0,
                         got.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (got != ref_run) $display("FAIL bp_vs_unstalled: %0d tokens stalled vs %0d unstalled, required identical",
                                 got.size(), ref_run.size());
    else n_pass++;
    n_chk++;
    if (got.size() != 4 * FRAME_TOKENS) $display("FAIL bp_count: got %0d required %0d", got.size(), 4 * FRAME_TOKENS);
    else n_pass++;
    n_chk++;
    if (viol != 0) $display("FAIL bp_wr_while_full: got %0d writes while full required 0", viol);
    else n_pass++;
    n_chk++;
    if (frame_count !== exp_cnt(exp_frames) || drop_count !== exp_cnt(exp_drops))
      $display("FAIL bp_counters: got frame=%h drop=%h required %h/%h",
               frame_count, drop_count, exp_cnt(exp_frames), exp_cnt(exp_drops));
    else n_pass++;
  endtask

  task automatic test_reset_mid_row();
    int d;
    do_reset();
    beats.delete();
    add(T_SOF, 16'h0);
    add(T_SOL, 16'h0);
    add(T_PIX, 16'h1111);
    add(T_PIX, 16'h2222);
    run_stream(0, 0);
    n_chk++;
    if (got.size() != 4 || got[3] !== 17'h02222)
      $display("FAIL midrow_partial: got %0d tokens required 4 ending in 02222", got.size());
    else n_pass++;
    // leave a token stuck in the slot behind a full FIFO, then reset
    @(posedge clk);
    #1;
    queue_full = 1'b1;
    in_valid = 1'b1;
    in_tag = T_PIX;
    in_data = 16'h5A5A;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL midrow_accept: in_ready %b required 1", in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    queue_full = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (queue_wr_en !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL midrow_in_reset: wr_en=%b in_ready=%b required 0/0", queue_wr_en, in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (queue_wr_en !== 1'b0) $display("FAIL midrow_wr_after_reset: got %b required 0", queue_wr_en);
    else n_pass++;
    @(posedge clk);
    #1;
    beats.delete();
    add(T_SOF, 16'h0);
    add_row(W);
    add(T_EOF, 16'h0);
    ref_model();
    run_stream(0, 0);
    d = first_diff();
    n_chk++;
    if (d >= 0) $display("FAIL midrow_clean_frame: index %0d got %h required %h (%0d vs %0d tokens)",
                         d, (d < got.size()) ? got[d] : 17'h0, (d < exp_q.size()) ? exp_q[d] : 17'h0,
                         got.size(), exp_q.size());
    else n_pass++;
    n_chk++;
    if (frame_count !== exp_cnt(1)) $display("FAIL midrow_fcnt: got %h required %h", frame_count, exp_cnt(1));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_row();
    test_missing_rows();
    test_crop();
    test_backpressure();
    test_reset_mid_row();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
